// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store data-memory master.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    function automatic logic [2:0] lsu_nbytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   lsu_nbytes = 3'd1;
            2'b01:   lsu_nbytes = 3'd2;
            default: lsu_nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem_master_align.sv
// Byte-lane logic: store lane mask and data placement, load extraction and extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_q0,
    input  logic [31:0] i_q1,
    output logic [7:0]  o_mask8,
    output logic [63:0] o_wd64,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_base;
    logic [31:0] w_raw;

    always_comb begin
        case (lsu_nbytes(i_funct3))
            3'd1:    w_base = 8'h01;
            3'd2:    w_base = 8'h03;
            default: w_base = 8'h0F;
        endcase
    end

    assign o_mask8 = w_base << i_off;
    assign o_wd64  = {32'b0, i_wdata} << {i_off, 3'b000};
    // Two captured words form a 64-bit window; the access starts at byte off.
    assign w_raw   = 32'({i_q1, i_q0} >> {i_off, 3'b000});

    always_comb begin
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_raw[7]}}, w_raw[7:0]};
            F3_BU:   o_rdata = {24'b0, w_raw[7:0]};
            F3_H:    o_rdata = {{16{w_raw[15]}}, w_raw[15:0]};
            F3_HU:   o_rdata = {16'b0, w_raw[15:0]};
            default: o_rdata = w_raw;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// RV32 load/store initiator: one request at a time, splits word-crossing accesses in two.
module lsu_dmem_master
    import lsu_pkg::*;
#(
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int          MEM_BYTES = 65536
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [15:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wren,
    input  logic [31:0] i_mem_q
);
    lsu_state_e  r_state;
    logic        r_we;
    logic        r_err;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;
    logic [31:0] r_q0;
    logic [31:0] r_q1;
    logic [15:0] r_mem_addr;
    logic [31:0] r_wdata_hold;

    logic [31:0] w_rel;
    logic [2:0]  w_n;
    logic        w_err;
    logic [7:0]  w_mask8;
    logic [63:0] w_wd64;
    logic [31:0] w_ld_data;
    logic [3:0]  w_wren;

    assign w_rel = i_req_addr - MEM_BASE;
    assign w_n   = lsu_nbytes(i_req_funct3);
    // Addresses below MEM_BASE wrap to a huge rel and fail the range check.
    assign w_err = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                   (i_req_funct3 == 3'b111) ||
                   (i_req_we && (i_req_funct3 == F3_BU || i_req_funct3 == F3_HU)) ||
                   (({1'b0, w_rel} + 33'(w_n)) > 33'(MEM_BYTES));

    lsu_align u_align (
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .i_wdata  (r_wdata),
        .i_q0     (r_q0),
        .i_q1     (r_q1),
        .o_mask8  (w_mask8),
        .o_wd64   (w_wd64),
        .o_rdata  (w_ld_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_f3         <= 3'b000;
            r_off        <= 2'b00;
            r_wdata      <= 32'b0;
            r_q0         <= 32'b0;
            r_q1         <= 32'b0;
            r_mem_addr   <= 16'b0;
            r_wdata_hold <= 32'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_we    <= i_req_we;
                        r_f3    <= i_req_funct3;
                        r_off   <= i_req_addr[1:0];
                        r_wdata <= i_req_wdata;
                        r_err   <= w_err;
                        r_q1    <= 32'b0;
                        if (w_err) begin
                            r_state <= RESP;
                        end else begin
                            r_mem_addr <= {w_rel[15:2], 2'b00};
                            r_state    <= ACC0;
                        end
                    end
                end
                ACC0: begin
                    r_q0         <= i_mem_q;
                    r_wdata_hold <= w_wd64[31:0];
                    if (w_mask8[7:4] != 4'b0000) begin
                        r_mem_addr <= r_mem_addr + 16'd4;
                        r_state    <= ACC1;
                    end else begin
                        r_state <= RESP;
                    end
                end
                ACC1: begin
                    r_q1         <= i_mem_q;
                    r_wdata_hold <= w_wd64[63:32];
                    r_state      <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_wren      = 4'b0000;
        o_mem_wdata = r_wdata_hold;
        case (r_state)
            ACC0: begin
                o_mem_wdata = w_wd64[31:0];
                if (r_we) w_wren = w_mask8[3:0];
            end
            ACC1: begin
                o_mem_wdata = w_wd64[63:32];
                if (r_we) w_wren = w_mask8[7:4];
            end
            default: ;
        endcase
    end

    assign o_mem_wren  = w_wren & {4{~i_reset}};
    assign o_mem_addr  = r_mem_addr;
    assign o_req_ready = (r_state == IDLE);
    assign o_rsp_valid = (r_state == RESP) && !i_reset;
    assign o_rsp_err   = o_rsp_valid && r_err;
    assign o_rsp_rdata = (o_rsp_valid && !r_err && !r_we) ? w_ld_data : 32'b0;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master with a byte-level reference memory and response scoreboard.
module tb_lsu_dmem_master;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = 3'b000;
    logic [31:0] i_req_addr = 32'b0;
    logic [31:0] i_req_wdata = 32'b0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [15:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wren;
    logic [31:0] i_mem_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] mem     [0:16383];
    logic [7:0]  ref_mem [0:65535];

    logic [3:0]  wren_log  [1:4];
    logic [15:0] addr_log  [1:4];
    logic [31:0] wdata_log [1:4];
    logic        any_wren;

    always #5 i_clk = ~i_clk;

    lsu_dmem_master #(.MEM_BASE(32'h0000_0000), .MEM_BYTES(65536)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wren   (o_mem_wren),
        .i_mem_q      (i_mem_q)
    );

    assign i_mem_q = mem[o_mem_addr[15:2]];

    always @(posedge i_clk) begin
        for (int b = 0; b < 4; b++)
            if (o_mem_wren[b]) mem[o_mem_addr[15:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (we && (f3 == 3'b100 || f3 == 3'b101)) return 1'b1;
        if (({1'b0, addr} + 33'(nbytes(f3))) > 33'd65536) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v = 32'b0;
        int n = nbytes(f3);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(addr) + i) & 16'hFFFF];
        case (f3)
            3'b000:  if (v[7])  v[31:8]  = 24'hFFFFFF;
            3'b001:  if (v[15]) v[31:16] = 16'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        exp_t e, got_e;
        int   cyc;
        logic got;
        e.err   = model_err(we, f3, addr);
        e.rdata = (e.err || we) ? 32'b0 : model_load(f3, addr);
        e.lat   = e.err ? 1 : ((int'(addr[1:0]) + nbytes(f3) > 4) ? 3 : 2);
        sb_q.push_back(e);
        if (!e.err && we)
            for (int i = 0; i < nbytes(f3); i++) ref_mem[(int'(addr) + i) & 16'hFFFF] = wd[8*i +: 8];
        @(negedge i_clk);
        chk({tag, "_ready"}, {31'b0, o_req_ready}, 32'd1);
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        @(posedge i_clk);
        cyc = 0;
        got = 1'b0;
        any_wren = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            wren_log[k] = 4'b0; addr_log[k] = 16'b0; wdata_log[k] = 32'b0;
        end
        while (!got && cyc < 8) begin
            @(negedge i_clk);
            cyc++;
            i_req_valid = 1'b0;
            if (cyc <= 4) begin
                wren_log[cyc]  = o_mem_wren;
                addr_log[cyc]  = o_mem_addr;
                wdata_log[cyc] = o_mem_wdata;
            end
            if (o_mem_wren != 4'b0) any_wren = 1'b1;
            if (o_rsp_valid) got = 1'b1;
        end
        chk({tag, "_rsp_seen"}, {31'b0, got}, 32'd1);
        got_e = sb_q.pop_front();
        if (got) begin
            chk({tag, "_rdata"}, o_rsp_rdata, got_e.rdata);
            chk({tag, "_err"}, {31'b0, o_rsp_err}, {31'b0, got_e.err});
            chk({tag, "_lat"}, cyc, got_e.lat);
        end
        if (got_e.err) chk({tag, "_no_wren"}, {31'b0, any_wren}, 32'd0);
        @(negedge i_clk);
        chk({tag, "_pulse_end"}, {31'b0, o_rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] w30_before;
        int          cyc;
        for (int w = 0; w < 16384; w++) begin
            v = $urandom;
            mem[w] = v;
            for (int b = 0; b < 4; b++) ref_mem[4*w+b] = v[8*b +: 8];
        end

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ready", {31'b0, o_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("rst_rdata", o_rsp_rdata, 32'd0);
        chk("rst_err", {31'b0, o_rsp_err}, 32'd0);
        chk("rst_mem_addr", {16'b0, o_mem_addr}, 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'd0);
        chk("rst_mem_wren", {28'b0, o_mem_wren}, 32'd0);
        i_reset = 1'b0;

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw10");
        chk("sw10_wren", {28'b0, wren_log[1]}, 32'hF);
        chk("sw10_addr", {16'b0, addr_log[1]}, 32'h10);
        chk("sw10_wdata", wdata_log[1], 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw10");

        do_req(1'b1, 3'b000, 32'h13, 32'h000000A5, "sb13");
        chk("sb13_wren", {28'b0, wren_log[1]}, 32'h8);
        chk("sb13_wdata_hi", {24'b0, wdata_log[1][31:24]}, 32'hA5);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, "lb13");
        do_req(1'b0, 3'b100, 32'h13, 32'h0, "lbu13");
        chk("lb_const", model_load(3'b000, 32'h13), 32'hFFFFFFA5);

        do_req(1'b1, 3'b010, 32'h1E, 32'h11223344, "sw1e");
        chk("sw1e_a0", {16'b0, addr_log[1]}, 32'h1C);
        chk("sw1e_w0", {28'b0, wren_log[1]}, 32'hC);
        chk("sw1e_d0", wdata_log[1], 32'h33440000);
        chk("sw1e_a1", {16'b0, addr_log[2]}, 32'h20);
        chk("sw1e_w1", {28'b0, wren_log[2]}, 32'h3);
        chk("sw1e_d1", wdata_log[2], 32'h00001122);
        do_req(1'b0, 3'b010, 32'h1E, 32'h0, "lw1e");
        do_req(1'b0, 3'b001, 32'h1F, 32'h0, "lh1f");
        do_req(1'b0, 3'b101, 32'h1F, 32'h0, "lhu1f");
        do_req(1'b1, 3'b001, 32'h41, 32'h0000C3D2, "sh41");
        do_req(1'b0, 3'b001, 32'h41, 32'h0, "lh41");
        do_req(1'b0, 3'b101, 32'h42, 32'h0, "lhu42");
        do_req(1'b0, 3'b010, 32'hFFFC, 32'h0, "lwtop");

        do_req(1'b0, 3'b010, 32'hFFFE, 32'h0, "lw_oor");
        do_req(1'b1, 3'b010, 32'h10000, 32'h12345678, "sw_oor");
        do_req(1'b0, 3'b011, 32'h10, 32'h0, "f3_011");
        do_req(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, "sbu");
        chk("mem_w10", mem[4], ref_word(4));
        chk("mem_wfffc", mem[16383], ref_word(16383));

        // Split store interrupted by reset in its second access.
        @(negedge i_clk);
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h2E;
        i_req_wdata  = 32'hCAFEF00D;
        w30_before   = ref_word(12);
        ref_mem[32'h2E] = 8'h0D;
        ref_mem[32'h2F] = 8'hF0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("rst_split_acc0_wren", {28'b0, o_mem_wren}, 32'hC);
        @(negedge i_clk);
        chk("rst_split_acc1_addr", {16'b0, o_mem_addr}, 32'h30);
        i_reset = 1'b1;
        #1;
        chk("rst_split_wren", {28'b0, o_mem_wren}, 32'd0);
        chk("rst_split_rsp", {31'b0, o_rsp_valid}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        chk("rst_split_ready", {31'b0, o_req_ready}, 32'd1);
        cyc = 0;
        repeat (3) begin
            @(negedge i_clk);
            if (o_rsp_valid) cyc++;
        end
        chk("rst_split_no_rsp", cyc, 32'd0);
        chk("rst_split_w2c", mem[11], ref_word(11));
        chk("rst_split_w30", mem[12], w30_before);

        do_req(1'b0, 3'b010, 32'h2C, 32'h0, "lw2c_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
